// File: rtl/log_pkg.sv
// Shared types and constants for the log RAM read path.
package log_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

endpackage

// File: rtl/log_rd_fifo.sv
// Small synchronous output buffer between the log RAM and the stream.
module log_rd_fifo
  import log_pkg::*;
#(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [OCC_W-1:0]  occ
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic              do_pop;

  assign do_pop = pop && (occ != '0);
  assign head   = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop)
        rptr <= rptr + 1'b1;
      occ <= occ + OCC_W'(push) - OCC_W'(do_pop);
    end
  end

endmodule

// File: rtl/log_ram_reader.sv
// Drains a circular log RAM into a valid/ready stream.
// Define LOGRD_LEVEL_EN to add the registered fill-level output.
module log_ram_reader
  import log_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 10
) (
  input  logic              clk_out,
  input  logic              rst,
  input  logic [ADDR_W-1:0] wr_ptr,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] raddr,
  output logic              rden,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic              busy
`ifdef LOGRD_LEVEL_EN
  ,
  output logic [ADDR_W:0]   level
`endif
);

  state_t            state;
  state_t            next;
  logic              issue;
  logic              inflight;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W:0]    pending;
  logic [ADDR_W-1:0] avail;
  logic [DATA_W-1:0] head;

  assign avail   = wr_ptr - rd_ptr;
  assign pending = {1'b0, occ} + (OCC_W + 1)'(inflight);

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= next;
  end

  always_comb begin
    next  = state;
    issue = 1'b0;
    unique case (state)
      IDLE:
        if (start && !stop)
          next = RUN;
      RUN: begin
        issue = (avail != '0) &&
                (pending < (OCC_W + 1)'(FIFO_DEPTH));
        if (stop)
          next = FLUSH;
      end
      FLUSH:
        if (!inflight && occ == '0)
          next = IDLE;
      default:
        next = IDLE;
    endcase
  end

  assign rden  = issue;
  assign raddr = issue ? rd_ptr : '0;
  assign busy  = (state != IDLE);

  // RAM data lands one cycle after rden, so inflight is at most one read.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  log_rd_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk_out),
    .rst   (rst),
    .push  (inflight),
    .wdata (rdata),
    .pop   (m_valid && m_ready),
    .head  (head),
    .occ   (occ)
  );

  assign m_valid = (occ != '0);
  assign m_data  = m_valid ? head : '0;

`ifdef LOGRD_LEVEL_EN
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst)
      level <= '0;
    else
      level <= {1'b0, avail} +
               (ADDR_W + 1)'(inflight) +
               (ADDR_W + 1)'(occ);
  end
`endif

endmodule

// File: tb/tb_log_ram_reader.sv
// Directed bench for log_ram_reader with a behavioural log RAM.
module tb_log_ram_reader;

  localparam int AW = 10;
  localparam int DW = 10;

  logic          clk_out = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] wr_ptr = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          m_ready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [AW-1:0] raddr;
  logic          rden;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic [AW-1:0] rd_ptr;
  logic          busy;
`ifdef LOGRD_LEVEL_EN
  logic [AW:0]   level;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int first_rden = -1;
  int first_valid = -1;
  logic [AW-1:0] rd_q[$];
  logic [DW-1:0] tx_q[$];

  log_ram_reader #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk_out (clk_out),
    .rst     (rst),
    .wr_ptr  (wr_ptr),
    .start   (start),
    .stop    (stop),
    .raddr   (raddr),
    .rden    (rden),
    .rdata   (rdata),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .rd_ptr  (rd_ptr),
`ifdef LOGRD_LEVEL_EN
    .level   (level),
`endif
    .busy    (busy)
  );

  always #5 clk_out = ~clk_out;

  function automatic logic [DW-1:0] ram(input int a);
    return DW'((a * 37 + 11) % 1024);
  endfunction

  always @(posedge clk_out)
    rdata <= rden ? ram(int'(raddr)) : '0;

  always @(negedge clk_out) begin
    cyc++;
    if (!rst) begin
      if (rden) begin
        rd_q.push_back(raddr);
        if (first_rden < 0) first_rden = cyc;
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (m_valid && m_ready) tx_q.push_back(m_data);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_out);
    #1;
  endtask

  task automatic clear_log();
    rd_q.delete();
    tx_q.delete();
    first_rden = -1;
    first_valid = -1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 50) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] d0;
    int n;

    // reset state
    #1 rst = 1'b1;
    tick(2);
    chk("rst_rden", 32'(rden), 32'd0);
    chk("rst_raddr", 32'(raddr), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdptr", 32'(rd_ptr), 32'd0);
    rst = 1'b0;
    tick(1);

    // start and stop together in IDLE
    wr_ptr = 10'd5;
    clear_log();
    start = 1'b1;
    stop = 1'b1;
    tick(1);
    start = 1'b0;
    stop = 1'b0;
    chk("both_busy0", 32'(busy), 32'd0);
    tick(3);
    chk("both_busy1", 32'(busy), 32'd0);
    chk("both_nordn", rd_q.size(), 32'd0);

    // basic drain of 5 words
    m_ready = 1'b1;
    clear_log();
    pulse_start();
    tick(12);
    chk("b_rdcnt", rd_q.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("b_addr", 32'(rd_q[i]), 32'(i));
    chk("b_txcnt", tx_q.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("b_data", 32'(tx_q[i]), 32'(ram(i)));
    chk("b_lat", 32'(first_valid - first_rden), 32'd2);
    chk("b_rdptr", 32'(rd_ptr), 32'd5);
    pulse_stop();
    wait_idle("b_idle");

    // advance to 1020, then wrap
    wr_ptr = 10'd1020;
    pulse_start();
    n = 0;
    while (rd_ptr != 10'd1020 && n < 1200) begin
      tick(1);
      n++;
    end
    chk("w_reach", 32'(rd_ptr), 32'd1020);
    pulse_stop();
    wait_idle("w_idle0");
    clear_log();
    wr_ptr = 10'd3;
    pulse_start();
    tick(15);
    chk("w_rdcnt", rd_q.size(), 32'd7);
    for (int i = 0; i < 7; i++)
      chk("w_addr", 32'(rd_q[i]), 32'((1020 + i) % 1024));
    chk("w_txcnt", tx_q.size(), 32'd7);
    for (int i = 0; i < 7; i++)
      chk("w_data", 32'(tx_q[i]),
          32'(ram((1020 + i) % 1024)));
    chk("w_rdptr", 32'(rd_ptr), 32'd3);
    pulse_stop();
    wait_idle("w_idle1");

    // backpressure with 10 available
    m_ready = 1'b0;
    wr_ptr = 10'd13;
    clear_log();
    pulse_start();
    tick(10);
    chk("bp_rdcnt", rd_q.size(), 32'd4);
    chk("bp_valid", 32'(m_valid), 32'd1);
    chk("bp_head", 32'(m_data), 32'(ram(3)));
    d0 = m_data;
    tick(3);
    chk("bp_stable", 32'(m_data), 32'(d0));
    chk("bp_rdcnt2", rd_q.size(), 32'd4);
    m_ready = 1'b1;
    tick(20);
    chk("bp_txcnt", tx_q.size(), 32'd10);
    for (int i = 0; i < 10; i++)
      chk("bp_data", 32'(tx_q[i]), 32'(ram(3 + i)));
    chk("bp_rdptr", 32'(rd_ptr), 32'd13);
    pulse_stop();
    wait_idle("bp_idle");

    // stop one cycle after a read
    wr_ptr = 10'd14;
    clear_log();
    pulse_start();
    chk("st_rden", 32'(rden), 32'd1);
    tick(1);
    pulse_stop();
    chk("st_busy", 32'(busy), 32'd1);
    tick(6);
    chk("st_rdcnt", rd_q.size(), 32'd1);
    chk("st_txcnt", tx_q.size(), 32'd1);
    chk("st_data", 32'(tx_q[0]), 32'(ram(13)));
    chk("st_busy0", 32'(busy), 32'd0);
    chk("st_rdptr", 32'(rd_ptr), 32'd14);

    // reset with 3 words buffered
    m_ready = 1'b0;
    wr_ptr = 10'd17;
    clear_log();
    pulse_start();
    tick(6);
    chk("r_valid1", 32'(m_valid), 32'd1);
    chk("r_rdcnt", rd_q.size(), 32'd3);
    rst = 1'b1;
    #1;
    chk("r_valid0", 32'(m_valid), 32'd0);
    chk("r_rdptr", 32'(rd_ptr), 32'd0);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_rden", 32'(rden), 32'd0);
    m_ready = 1'b1;
    tick(1);
    rst = 1'b0;
    n = tx_q.size();
    tick(3);
    chk("r_notx", tx_q.size(), 32'(n));
    chk("r_valid2", 32'(m_valid), 32'd0);
    chk("r_busy2", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/log_ram_reader.md
LOG_RAM_READER -- requirements
Module: log_ram_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: log RAM address width; depth is 2**ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 10: log entry width.
REQ-003 SHALL have port clk_out, input, 1: single clock, the read-side clock of the log RAM.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port wr_ptr, input, ADDR_W: writer's next-write address, already synchronized into clk_out.
REQ-006 SHALL have port start, input, 1: one-cycle pulse that begins draining.
REQ-007 SHALL have port stop, input, 1: one-cycle pulse that ends draining.
REQ-008 SHALL have port raddr, output, ADDR_W: RAM read address.
REQ-009 SHALL have port rden, output, 1: RAM read enable.
REQ-010 SHALL have port rdata, input, DATA_W: RAM read data, valid the cycle after rden; zero otherwise.
REQ-011 SHALL have port m_data, output, DATA_W: stream data.
REQ-012 SHALL have ports m_valid, output, 1 and m_ready, input, 1: stream handshake.
REQ-013 SHALL have port rd_ptr, output, ADDR_W: next address to read, returned to the writer for its full check.
REQ-014 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> RUN on start; RUN -> FLUSH on stop; FLUSH -> IDLE once inflight==0 and the buffer is empty.
REQ-016 SHALL resolve start and stop asserted together in IDLE as "stay IDLE", and SHALL ignore start outside IDLE.
REQ-017 SHALL compute avail = (wr_ptr - rd_ptr) mod 2**ADDR_W.
REQ-018 SHALL issue a read in RUN when avail>0 and occ+inflight<4.
REQ-019 SHALL, on each issue cycle, drive rden=1 and raddr=rd_ptr combinationally, then increment rd_ptr at that edge, wrapping 2**ADDR_W-1 -> 0.
REQ-020 SHALL hold rden=0 outside issue cycles and SHALL never issue in IDLE or FLUSH.
REQ-021 SHALL write rdata into a 4-entry output FIFO at the end of the cycle after issue; inflight counts reads issued but not yet captured.
REQ-022 SHALL assert m_valid whenever the FIFO is non-empty, with m_data = FIFO head; first m_valid occurs 2 cycles after the first rden.
REQ-023 SHALL hold m_data stable while m_valid && !m_ready, and SHALL pop the head on m_valid && m_ready.
REQ-024 SHALL sustain one transfer per cycle when m_ready is held high and avail>=1 continuously.
REQ-025 SHALL still capture and deliver reads already in flight when stop arrives.
REQ-026 SHALL treat avail==0 as empty, issuing nothing and leaving rd_ptr unchanged.
REQ-027 SHALL include no overrun detection; the writer guarantees it never passes rd_ptr.

Reset
REQ-028 SHALL, on rst asserted (asynchronous), set state=IDLE, rd_ptr=0, inflight=0, FIFO empty, m_valid=0, m_data=0, rden=0, raddr=0, busy=0.
REQ-029 SHALL, on reset mid-operation, discard data in flight and in the FIFO and SHALL NOT produce a stream transfer in the cycle after release.

Configuration
REQ-030 SHALL, with LOGRD_LEVEL_EN defined, add output level (ADDR_W+1 bits) = avail + inflight + occ, registered, reset 0.
REQ-031 SHALL, without LOGRD_LEVEL_EN, omit the port level and its logic entirely, with all other behaviour identical.

Structure
REQ-032 SHALL place the FSM state enum and the FIFO depth constant (4) in shared package log_pkg.
REQ-033 SHALL implement the output buffer as sub-module log_rd_fifo (4-deep, synchronous, with push/pop/occ).

Verification
REQ-034 SHALL verify: wr_ptr=5, start, m_ready=1 -> rden at addresses 0..4, 5 transfers with the RAM contents in order, m_valid first seen 2 cycles after first rden, rd_ptr=5.
REQ-035 SHALL verify: rd_ptr=1020, wr_ptr=3 -> 7 reads at 1020..1023, 0..2, rd_ptr=3.
REQ-036 SHALL verify: m_ready=0 with 10 entries available -> exactly 4 rden pulses, then m_data stable; releasing m_ready -> all 10 entries delivered in order.
REQ-037 SHALL verify: stop one cycle after a rden -> that word is still delivered, no further rden, busy falls once the FIFO is empty.
REQ-038 SHALL verify: start and stop together in IDLE -> busy stays 0 and no rden.
REQ-039 SHALL verify: rst pulse with 3 words buffered -> m_valid=0 immediately, rd_ptr=0, no transfer after release.
